// File: rtl/ts4231_pkg.sv
// Shared TS4231 definitions: reply width, default config word
// and the sensor configuration scheduler state encoding.
package ts4231_pkg;

    localparam int REPLY_W = 15;

    localparam logic [REPLY_W-1:0] CFG_WORD_DEFAULT = 15'h392B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_NEXT,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for signals crossing in from another
// clock domain; reset value is selectable per instance.
module sync_2ff #(
    parameter int                WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Metastability stage followed by the settled output stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sensor_cfg_scheduler.sv
// Sequences TS4231 init engines one at a time, verifies each
// readback and retries failed attempts up to MAX_RETRY times.
module sensor_cfg_scheduler
    import ts4231_pkg::*;
#(
    parameter int                  NUM_SENSORS = 4,
    parameter logic [REPLY_W-1:0] CFG_WORD    = CFG_WORD_DEFAULT,
    parameter int                  MAX_RETRY   = 3,
    parameter int                  TIMEOUT_CYC = 100_000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           run,
    output logic [NUM_SENSORS-1:0]         start_cfg,
    input  logic [NUM_SENSORS-1:0]         cfg_done,
    input  logic [REPLY_W*NUM_SENSORS-1:0] cfg_data_reply,
    output logic [NUM_SENSORS-1:0]         sensor_ok,
    output logic [NUM_SENSORS-1:0]         sensor_fail,
    output logic                           busy,
    output logic                           sweep_done,
    output logic [3:0]                     cur_sensor
);

    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TW-1:0]          TIMER_LOAD = TW'(TIMEOUT_CYC);
    localparam logic [RW-1:0]          RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [3:0]             LAST       = 4'(NUM_SENSORS - 1);
    localparam logic [NUM_SENSORS-1:0] ONE        = NUM_SENSORS'(1);

    sched_state_e             state;
    logic [TW-1:0]            timer;
    logic [RW-1:0]            retry_cnt;
    logic [NUM_SENSORS-1:0]   done_s;
    logic                     done_sel;
    logic [REPLY_W-1:0]       reply_sel;
    logic [NUM_SENSORS-1:0]   cur_bit;
    logic                     attempt_fail;

    // Engines idle with done high, so the synchroniser resets high
    // to avoid a false "accepted" right after reset release.
    sync_2ff #(
        .WIDTH   (NUM_SENSORS),
        .RST_VAL ({NUM_SENSORS{1'b1}})
    ) u_done_sync (
        .clock (clock),
        .reset (reset),
        .d     (cfg_done),
        .q     (done_s)
    );

    // Select the done flag and readback of the sensor being served.
    always_comb begin
        done_sel  = 1'b0;
        reply_sel = '0;
        cur_bit   = ONE << cur_sensor;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (cur_sensor == 4'(i)) begin
                done_sel  = done_s[i];
                reply_sel = cfg_data_reply[REPLY_W*i +: REPLY_W];
            end
        end
    end

    // An attempt fails on timeout while waiting or on a bad readback.
    always_comb begin
        unique case (state)
            ST_WAIT_START,
            ST_WAIT_DONE:  attempt_fail = (timer == '0);
            ST_CHECK:      attempt_fail = (reply_sel != CFG_WORD);
            default:       attempt_fail = 1'b0;
        endcase
    end

    // Sweep FSM with registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            retry_cnt   <= '0;
            start_cfg   <= '0;
            sensor_ok   <= '0;
            sensor_fail <= '0;
            busy        <= 1'b0;
            sweep_done  <= 1'b0;
            cur_sensor  <= '0;
        end else begin
            sweep_done <= 1'b0;
            if (attempt_fail) begin
                start_cfg <= '0;
                if (retry_cnt < RETRY_MAX) begin
                    retry_cnt <= retry_cnt + 1'b1;
                    state     <= ST_ARM;
                end else begin
                    sensor_fail <= sensor_fail | cur_bit;
                    state       <= ST_NEXT;
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (run) begin
                            sensor_ok   <= '0;
                            sensor_fail <= '0;
                            cur_sensor  <= '0;
                            retry_cnt   <= '0;
                            busy        <= 1'b1;
                            state       <= ST_ARM;
                        end
                    end
                    ST_ARM: begin
                        start_cfg <= cur_bit;
                        timer     <= TIMER_LOAD;
                        state     <= ST_WAIT_START;
                    end
                    ST_WAIT_START: begin
                        if (!done_sel) begin
                            start_cfg <= '0;
                            timer     <= TIMER_LOAD;
                            state     <= ST_WAIT_DONE;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (done_sel) begin
                            state <= ST_CHECK;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        sensor_ok <= sensor_ok | cur_bit;
                        state     <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        retry_cnt <= '0;
                        if (cur_sensor == LAST) begin
                            state <= ST_DONE;
                        end else begin
                            cur_sensor <= cur_sensor + 1'b1;
                            state      <= ST_ARM;
                        end
                    end
                    ST_DONE: begin
                        busy       <= 1'b0;
                        sweep_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sensor_cfg_scheduler.sv
// Scoreboard bench for sensor_cfg_scheduler: behavioural init
// engines, per-sweep expected outcomes, decoupled monitor.
module tb_sensor_cfg_scheduler;
    import ts4231_pkg::*;

    localparam int NS = 4;
    localparam int MR = 3;
    localparam int TO = 50;
    localparam logic [14:0] CW = 15'h392B;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            run   = 1'b0;
    logic [NS-1:0]   start_cfg;
    logic [NS-1:0]   cfg_done;
    logic [15*NS-1:0] cfg_data_reply;
    logic [NS-1:0]   sensor_ok;
    logic [NS-1:0]   sensor_fail;
    logic            busy;
    logic            sweep_done;
    logic [3:0]      cur_sensor;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [NS-1:0]      ok;
        logic [NS-1:0]      fail;
        logic [NS-1:0]      stk;
        logic [NS-1:0][7:0] att;
    } exp_t;

    exp_t exp_q[$];

    int          bad_n[NS];
    bit          stuck[NS];
    logic [14:0] bad_val[NS];
    int          gen = 0;

    always #5 clock = ~clock;

    sensor_cfg_scheduler #(
        .NUM_SENSORS (NS),
        .CFG_WORD    (CW),
        .MAX_RETRY   (MR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .start_cfg      (start_cfg),
        .cfg_done       (cfg_done),
        .cfg_data_reply (cfg_data_reply),
        .sensor_ok      (sensor_ok),
        .sensor_fail    (sensor_fail),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .cur_sensor     (cur_sensor)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Init engine models: accept a start request, go busy for a
    // random time, then raise done with a good or bad readback.
    initial begin
        int cnt[NS];
        bit eb[NS];
        int att[NS];
        int seen;
        seen = 0;
        cfg_done = '1;
        cfg_data_reply = '0;
        for (int i = 0; i < NS; i++) begin
            cnt[i] = 0;
            eb[i] = 1'b0;
            att[i] = 0;
        end
        forever begin
            @(negedge clock);
            if (gen != seen) begin
                seen = gen;
                for (int i = 0; i < NS; i++) att[i] = 0;
            end
            for (int i = 0; i < NS; i++) begin
                if (eb[i]) begin
                    if (cnt[i] == 0) begin
                        eb[i] = 1'b0;
                        cfg_done[i] = 1'b1;
                        cfg_data_reply[15*i +: 15] =
                            (att[i] <= bad_n[i]) ? bad_val[i] : CW;
                    end else begin
                        cnt[i]--;
                    end
                end else if (start_cfg[i] && !stuck[i] && cfg_done[i]) begin
                    eb[i] = 1'b1;
                    att[i]++;
                    cfg_done[i] = 1'b0;
                    cnt[i] = int'($urandom_range(4, 20));
                end
            end
        end
    end

    // Monitor: gathers per-sweep observations and compares them with
    // the oldest expected entry whenever sweep_done pulses.
    initial begin
        int pulses[NS];
        int w[NS];
        int maxw[NS];
        logic [NS-1:0] prev;
        int viol;
        int order_err;
        int last;
        int first;
        exp_t e;
        prev = '0;
        viol = 0;
        order_err = 0;
        last = -1;
        first = -1;
        for (int i = 0; i < NS; i++) begin
            pulses[i] = 0;
            w[i] = 0;
            maxw[i] = 0;
        end
        forever begin
            @(negedge clock);
            if (!reset) begin
                prev = '0;
                viol = 0;
                order_err = 0;
                last = -1;
                first = -1;
                for (int i = 0; i < NS; i++) begin
                    pulses[i] = 0;
                    w[i] = 0;
                    maxw[i] = 0;
                end
                continue;
            end
            if ($countones(start_cfg) > 1 || cur_sensor > 4'(NS - 1))
                viol++;
            for (int i = 0; i < NS; i++) begin
                if (start_cfg[i]) begin
                    w[i]++;
                    if (!prev[i]) begin
                        pulses[i]++;
                        if (i < last) order_err++;
                        last = i;
                        if (first < 0) first = i;
                    end
                    if (w[i] > maxw[i]) maxw[i] = w[i];
                end else begin
                    w[i] = 0;
                end
            end
            prev = start_cfg;
            if (sweep_done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_sweep_done: got 1 expected 0");
                end else begin
                    e = exp_q.pop_front();
                    chk("sensor_ok", 64'(sensor_ok), 64'(e.ok));
                    chk("sensor_fail", 64'(sensor_fail), 64'(e.fail));
                    for (int i = 0; i < NS; i++) begin
                        chk($sformatf("attempts[%0d]", i),
                            64'(pulses[i]), 64'(e.att[i]));
                        if (e.stk[i])
                            chk($sformatf("timeout_width[%0d]", i),
                                64'(maxw[i] >= TO && maxw[i] <= TO + 2), 64'(1));
                    end
                    chk("one_hot_violations", 64'(viol), 64'(0));
                    chk("order_errors", 64'(order_err), 64'(0));
                    chk("first_sensor", 64'(first), 64'(0));
                end
                viol = 0;
                order_err = 0;
                last = -1;
                first = -1;
                for (int i = 0; i < NS; i++) begin
                    pulses[i] = 0;
                    maxw[i] = 0;
                end
            end
        end
    end

    task automatic cfg_all_good();
        for (int i = 0; i < NS; i++) begin
            bad_n[i] = 0;
            stuck[i] = 1'b0;
            bad_val[i] = 15'h0000;
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            tests++;
            fails++;
            $display("FAIL %s: still busy after %0d cycles", name, n);
        end
    endtask

    task automatic do_sweep(input bit poke);
        exp_t e;
        int a;
        e = '0;
        for (int i = 0; i < NS; i++) begin
            if (stuck[i]) begin
                a = MR + 1;
            end else if (bad_n[i] <= MR) begin
                a = bad_n[i] + 1;
                e.ok[i] = 1'b1;
            end else begin
                a = MR + 1;
            end
            e.fail[i] = !e.ok[i];
            e.stk[i] = stuck[i];
            e.att[i] = 8'(a);
        end
        gen++;
        exp_q.push_back(e);
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        chk("latency_cycle1", 64'(start_cfg), 64'(0));
        chk("busy_after_run", 64'(busy), 64'(1));
        @(negedge clock);
        chk("latency_cycle2", 64'(start_cfg), 64'(1));
        if (poke) begin
            repeat (30) @(negedge clock);
            run = 1'b1;
            @(negedge clock);
            run = 1'b0;
        end
        wait_idle("sweep_timeout");
        repeat (3) @(negedge clock);
        chk("hold_ok", 64'(sensor_ok), 64'(e.ok));
        chk("hold_fail", 64'(sensor_fail), 64'(e.fail));
    endtask

    task automatic wait_start(input int idx, input logic lvl);
        int n;
        n = 0;
        while (start_cfg[idx] !== lvl && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (start_cfg[idx] !== lvl) begin
            tests++;
            fails++;
            $display("FAIL wait_start[%0d]: got %0b expected %0b",
                     idx, start_cfg[idx], lvl);
        end
    endtask

    initial begin
        cfg_all_good();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_start_cfg", 64'(start_cfg), 64'(0));
        chk("rst_sensor_ok", 64'(sensor_ok), 64'(0));
        chk("rst_sensor_fail", 64'(sensor_fail), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sweep_done", 64'(sweep_done), 64'(0));
        chk("rst_cur_sensor", 64'(cur_sensor), 64'(0));
        reset = 1'b1;
        repeat (5) @(negedge clock);

        cfg_all_good();
        do_sweep(1'b0);

        cfg_all_good();
        bad_n[2] = 100;
        do_sweep(1'b0);

        cfg_all_good();
        bad_n[1] = 1;
        do_sweep(1'b0);

        cfg_all_good();
        stuck[3] = 1'b1;
        do_sweep(1'b0);

        cfg_all_good();
        bad_n[0] = 2;
        do_sweep(1'b1);

        cfg_all_good();
        gen++;
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        wait_start(1, 1'b1);
        wait_start(1, 1'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_start_cfg", 64'(start_cfg), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_cur_sensor", 64'(cur_sensor), 64'(0));
        chk("mid_rst_sensor_ok", 64'(sensor_ok), 64'(0));
        chk("mid_rst_sweep_done", 64'(sweep_done), 64'(0));
        repeat (5) @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        chk("post_rst_busy", 64'(busy), 64'(0));
        do_sweep(1'b0);

        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < NS; i++) begin
                bad_n[i] = int'($urandom_range(0, 5));
                stuck[i] = ($urandom_range(0, 5) == 0);
                bad_val[i] = CW ^ 15'($urandom_range(1, 32767));
            end
            do_sweep(s[0]);
        end

        repeat (10) @(negedge clock);
        chk("pending_expect", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
